// File: rtl/stack_sequencer.sv
// PUSH/POP sequencer: moves a 16-bit register pair to/from the byte-wide stack and writes SP back.
// Optional SP wrap detection enabled by defining STACK_SEQ_WRAP_DETECT_EN.
module stack_sequencer #(
   parameter logic [3:0] SP_IDX = 4'd9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        op,
   input  logic [3:0]  pair,
   output logic        busy,
   output logic        done,
   output logic [3:0]  rd_reg1,
   input  logic [7:0]  rd_data1,
   input  logic [7:0]  rd_data1_lo,
   output logic [3:0]  rd_reg2,
   input  logic [7:0]  rd_data2,
   input  logic [7:0]  rd_data2_lo,
   output logic [3:0]  wr_reg,
   output logic [15:0] wr_data,
   output logic [1:0]  write_flag,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic        sp_wrap
);

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 8;
   localparam int unsigned RW = 4;
   localparam logic [1:0] WF_PAIR = 2'd2;

   typedef enum logic [2:0] {
      IDLE, P_HI, P_LO, P_SP, O_LO, O_HI, O_PAIR, O_SP
   } state_t;

   state_t         state, stateNext;
   logic [RW-1:0]  pairQ;
   logic [AW-1:0]  spQ;
   logic [AW-1:0]  dataQ;
   logic [DW-1:0]  loQ;
   logic [DW-1:0]  hiQ;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   // Operands are snapshotted at start so later register-file writes cannot disturb the operation
   always_ff @(posedge clk) begin
      if (rst) begin
         pairQ <= '0;
         spQ   <= '0;
         dataQ <= '0;
         loQ   <= '0;
         hiQ   <= '0;
      end else begin
         if (state == IDLE && start) begin
            pairQ <= pair;
            spQ   <= {rd_data2, rd_data2_lo};
            dataQ <= {rd_data1, rd_data1_lo};
         end
         if (state == O_LO && mem_ack) loQ <= mem_rdata;
         if (state == O_HI && mem_ack) hiQ <= mem_rdata;
      end
   end

   assign rd_reg2 = SP_IDX;

`ifdef STACK_SEQ_WRAP_DETECT_EN
   logic pushWrap;
   logic popWrap;
   assign pushWrap = (spQ <= 16'h0001);
   assign popWrap  = (spQ >= 16'hFFFE);
   assign sp_wrap  = (state == P_SP && pushWrap) || (state == O_SP && popWrap);
`else
   assign sp_wrap = 1'b0;
`endif

   // Next state and Moore outputs; bus outputs depend only on state so they hold through wait states
   always_comb begin
      stateNext  = state;
      busy       = (state != IDLE);
      done       = 1'b0;
      rd_reg1    = (state == IDLE) ? pair : pairQ;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      wr_reg     = '0;
      wr_data    = '0;
      write_flag = 2'd0;
      case (state)
         IDLE: begin
            if (start) stateNext = op ? O_LO : P_HI;
         end
         P_HI: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = spQ - 16'd1;
            mem_wdata = dataQ[15:8];
            if (mem_ack) stateNext = P_LO;
         end
         P_LO: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = spQ - 16'd2;
            mem_wdata = dataQ[7:0];
            if (mem_ack) stateNext = P_SP;
         end
         P_SP: begin
            write_flag = WF_PAIR;
            wr_reg     = SP_IDX;
            wr_data    = spQ - 16'd2;
            done       = 1'b1;
            stateNext  = IDLE;
         end
         O_LO: begin
            mem_req  = 1'b1;
            mem_addr = spQ;
            if (mem_ack) stateNext = O_HI;
         end
         O_HI: begin
            mem_req  = 1'b1;
            mem_addr = spQ + 16'd1;
            if (mem_ack) stateNext = O_PAIR;
         end
         O_PAIR: begin
            write_flag = WF_PAIR;
            wr_reg     = pairQ;
            wr_data    = {hiQ, loQ};
            stateNext  = O_SP;
         end
         O_SP: begin
            write_flag = WF_PAIR;
            wr_reg     = SP_IDX;
            wr_data    = spQ + 16'd2;
            done       = 1'b1;
            stateNext  = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: expected bus/register-file events are queued by the
// stimulus and popped by a negedge monitor; a responder process models memory with wait states.
module tb_stack_sequencer;

   localparam logic [3:0] SPI = 4'd9;
`ifdef STACK_SEQ_WRAP_DETECT_EN
   localparam logic WRAP_ON = 1'b1;
`else
   localparam logic WRAP_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [3:0]  pair = 4'd5;
   logic        busy, done, mem_req, mem_we, sp_wrap;
   logic [3:0]  rd_reg1, rd_reg2, wr_reg;
   logic [7:0]  rd_data1 = '0, rd_data1_lo = '0, rd_data2 = '0, rd_data2_lo = '0;
   logic [15:0] wr_data, mem_addr;
   logic [1:0]  write_flag;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = '0;
   logic        mem_ack = 1'b0;

   stack_sequencer #(.SP_IDX(SPI)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .pair(pair),
      .busy(busy), .done(done),
      .rd_reg1(rd_reg1), .rd_data1(rd_data1), .rd_data1_lo(rd_data1_lo),
      .rd_reg2(rd_reg2), .rd_data2(rd_data2), .rd_data2_lo(rd_data2_lo),
      .wr_reg(wr_reg), .wr_data(wr_data), .write_flag(write_flag),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .sp_wrap(sp_wrap)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          kind;    // 0 bus transaction, 1 register-file write
      logic        we;
      logic [15:0] addr;
      logic [7:0]  bdata;
      logic [3:0]  regIdx;
      logic [15:0] wdata;
      logic        dn;
      logic        wrap;
      int          cycNo;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          t0 = 0;
   int          waits = 0;
   logic        ackPulse = 1'b0;
   logic [7:0]  mem [logic [15:0]];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void expBus(input logic we, input logic [15:0] addr, input logic [7:0] d);
      exp_t e;
      e = '{kind: 0, we: we, addr: addr, bdata: d, regIdx: 4'd0, wdata: 16'd0,
            dn: 1'b0, wrap: 1'b0, cycNo: 0};
      q.push_back(e);
   endfunction

   function automatic void expWr(input logic [3:0] r, input logic [15:0] d, input logic dn,
                                 input logic wrap, input int c);
      exp_t e;
      e = '{kind: 1, we: 1'b0, addr: 16'd0, bdata: 8'd0, regIdx: r, wdata: d,
            dn: dn, wrap: wrap, cycNo: c};
      q.push_back(e);
   endfunction

   // Memory responder: acks after `waits` idle cycles of a held request
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         if (ackPulse) begin
            mem_ack  = 1'b1;
            ackPulse = 1'b0;
         end else if (mem_req) begin
            if (cnt == waits) begin
               mem_ack = 1'b1;
               cnt = 0;
               if (mem_we) mem[mem_addr] = mem_wdata;
               else        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT completes a bus transaction or writes a register
   initial begin
      logic        prevReq;
      logic        prevAck;
      logic [15:0] prevAddr;
      exp_t        e;
      prevReq = 1'b0; prevAck = 1'b0; prevAddr = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prevReq = 1'b0;
         end else begin
            if (mem_req && prevReq && !prevAck) check("addr_stable", 32'(mem_addr), 32'(prevAddr));
            if (mem_req && mem_ack) begin
               if (q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_bus: got addr 0x%0h we %0d expected no transaction", mem_addr, mem_we);
               end else begin
                  e = q.pop_front();
                  check("bus_kind", 32'(0), 32'(e.kind));
                  check("bus_we", 32'(mem_we), 32'(e.we));
                  check("bus_addr", 32'(mem_addr), 32'(e.addr));
                  if (e.we) check("bus_wdata", 32'(mem_wdata), 32'(e.bdata));
               end
            end
            if (write_flag != 2'd0) begin
               if (q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_write: got reg %0d data 0x%0h expected no write", wr_reg, wr_data);
               end else begin
                  e = q.pop_front();
                  check("wr_kind", 32'(1), 32'(e.kind));
                  check("write_flag", 32'(write_flag), 32'(2));
                  check("wr_reg", 32'(wr_reg), 32'(e.regIdx));
                  check("wr_data", 32'(wr_data), 32'(e.wdata));
                  check("done", 32'(done), 32'(e.dn));
                  check("sp_wrap", 32'(sp_wrap), 32'(e.wrap));
                  if (e.cycNo != 0) check("wr_cycle", 32'(cyc - t0 + 1), 32'(e.cycNo));
               end
            end else begin
               check("done_idle", 32'(done), 32'(0));
               check("wrap_idle", 32'(sp_wrap), 32'(0));
            end
            prevReq  = mem_req;
            prevAck  = mem_ack;
            prevAddr = mem_addr;
         end
      end
   end

   task automatic doOp(input logic o, input logic [3:0] p, input logic [15:0] sp, input logic [15:0] d);
      op = o; pair = p;
      rd_data2 = sp[15:8]; rd_data2_lo = sp[7:0];
      rd_data1 = d[15:8];  rd_data1_lo = d[7:0];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      t0 = cyc;
      rd_data1 = 8'hEE; rd_data1_lo = 8'hDD; rd_data2 = 8'hCC; rd_data2_lo = 8'hBB;
   endtask

   task automatic waitDone(input string name);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done) begin got = 1'b1; break; end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL %s_timeout: got no done expected done within 50 cycles", name);
      end
      @(posedge clk); #1;
      check({name, "_idle_after"}, 32'(busy), 32'(0));
   endtask

   task automatic waitAddr(input string name, input logic [15:0] a);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (mem_req && mem_addr == a) begin got = 1'b1; break; end
         @(posedge clk); #1;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL %s_timeout: got no request expected addr 0x%0h", name, a);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_req", 32'(mem_req), 32'(0));
      check("rst_we", 32'(mem_we), 32'(0));
      check("rst_wflag", 32'(write_flag), 32'(0));
      check("rst_wrap", 32'(sp_wrap), 32'(0));
      check("rst_addr", 32'(mem_addr), 32'(0));
      check("rst_wdata", 32'(mem_wdata), 32'(0));
      check("rst_wr_reg", 32'(wr_reg), 32'(0));
      check("rst_wr_data", 32'(wr_data), 32'(0));
      check("rst_rd_reg1", 32'(rd_reg1), 32'(5));
      check("rst_rd_reg2", 32'(rd_reg2), 32'(9));
      @(posedge clk); #1;
      rst = 1'b0;

      // PUSH zero-wait: SP 0xFFFE, pair 0x1234
      waits = 0;
      expBus(1'b1, 16'hFFFD, 8'h12);
      expBus(1'b1, 16'hFFFC, 8'h34);
      expWr(SPI, 16'hFFFC, 1'b1, 1'b0, 3);
      doOp(1'b0, 4'd2, 16'hFFFE, 16'h1234);
      waitDone("push0");

      // Back-to-back POP zero-wait of the bytes just pushed
      expBus(1'b0, 16'hFFFC, 8'h00);
      expBus(1'b0, 16'hFFFD, 8'h00);
      expWr(4'd2, 16'h1234, 1'b0, 1'b0, 3);
      expWr(SPI, 16'hFFFE, 1'b1, 1'b0, 4);
      doOp(1'b1, 4'd2, 16'hFFFC, 16'h0000);
      waitDone("pop0");

      // POP with two wait states per access
      waits = 2;
      expBus(1'b0, 16'hFFFC, 8'h00);
      expBus(1'b0, 16'hFFFD, 8'h00);
      expWr(4'd4, 16'h1234, 1'b0, 1'b0, 7);
      expWr(SPI, 16'hFFFE, 1'b1, 1'b0, 8);
      doOp(1'b1, 4'd4, 16'hFFFC, 16'h0000);
      waitDone("pop2");

      // PUSH wrapping below 0x0000
      waits = 0;
      expBus(1'b1, 16'h0000, 8'hAB);
      expBus(1'b1, 16'hFFFF, 8'hCD);
      expWr(SPI, 16'hFFFF, 1'b1, WRAP_ON, 3);
      doOp(1'b0, 4'd4, 16'h0001, 16'hABCD);
      waitDone("pushwrap");

      // POP wrapping above 0xFFFF
      expBus(1'b0, 16'hFFFF, 8'h00);
      expBus(1'b0, 16'h0000, 8'h00);
      expWr(4'd6, 16'hABCD, 1'b0, 1'b0, 3);
      expWr(SPI, 16'h0001, 1'b1, WRAP_ON, 4);
      doOp(1'b1, 4'd6, 16'hFFFF, 16'h0000);
      waitDone("popwrap");

      // PUSH SP itself
      expBus(1'b1, 16'h0FFF, 8'h10);
      expBus(1'b1, 16'h0FFE, 8'h00);
      expWr(SPI, 16'h0FFE, 1'b1, 1'b0, 3);
      doOp(1'b0, SPI, 16'h1000, 16'h1000);
      waitDone("pushsp");

      // Start while busy is ignored
      waits = 1;
      expBus(1'b1, 16'h1FFF, 8'h55);
      expBus(1'b1, 16'h1FFE, 8'h66);
      expWr(SPI, 16'h1FFE, 1'b1, 1'b0, 5);
      doOp(1'b0, 4'd6, 16'h2000, 16'h5566);
      waitAddr("busy_start", 16'h1FFE);
      op = 1'b1; pair = 4'd8; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("rd_reg1_latched", 32'(rd_reg1), 32'(6));
      waitDone("busystart");
      repeat (4) @(posedge clk); #1;
      check("busystart_quiet", 32'(busy), 32'(0));
      check("busystart_queue", 32'(q.size()), 32'(0));

      // Reset during O_HI
      waits = 2;
      expBus(1'b0, 16'h3000, 8'h00);
      doOp(1'b1, 4'd2, 16'h3000, 16'h0000);
      waitAddr("rst_mid", 16'h3001);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rstmid_busy", 32'(busy), 32'(0));
      check("rstmid_req", 32'(mem_req), 32'(0));
      check("rstmid_wflag", 32'(write_flag), 32'(0));
      check("rstmid_done", 32'(done), 32'(0));
      repeat (5) @(posedge clk); #1;
      check("rstmid_queue", 32'(q.size()), 32'(0));

      // Ack pulse while idle
      @(negedge clk);
      ackPulse = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("idleack_busy", 32'(busy), 32'(0));
      check("idleack_req", 32'(mem_req), 32'(0));
      check("idleack_wflag", 32'(write_flag), 32'(0));
      check("idleack_addr", 32'(mem_addr), 32'(0));
      check("idleack_wr_data", 32'(wr_data), 32'(0));
      repeat (2) @(posedge clk); #1;
      check("final_queue", 32'(q.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
